// File: rtl/knap8_pkg.sv
// Shared item tables, state encoding and widths for the 8-item knapsack sweep.
package knap8_pkg;

  localparam int N_ITEMS = 8;
  localparam int SUM_W   = 10;

  // Entry i belongs to item i (bit i of a candidate); A is entry 0.
  localparam logic [7:0] ITEM_VALUE  [N_ITEMS] = '{8'd4,  8'd8, 8'd0,  8'd20, 8'd10, 8'd12, 8'd18, 8'd14};
  localparam logic [7:0] ITEM_WEIGHT [N_ITEMS] = '{8'd28, 8'd8, 8'd27, 8'd18, 8'd27, 8'd28, 8'd6,  8'd1};
  localparam logic [7:0] ITEM_VOLUME [N_ITEMS] = '{8'd27, 8'd27, 8'd4, 8'd4,  8'd0,  8'd24, 8'd4,  8'd20};

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } state_t;

endpackage

// File: rtl/knap8_eval.sv
// Combinational sums of value, weight and volume over the items selected by a candidate.
// Zero latency; no flow control of its own.
module knap8_eval
  import knap8_pkg::*;
(
  input  logic [N_ITEMS-1:0] cand,
  output logic [SUM_W-1:0]   value_sum,
  output logic [SUM_W-1:0]   weight_sum,
  output logic [SUM_W-1:0]   volume_sum
);

  always_comb begin
    value_sum  = '0;
    weight_sum = '0;
    volume_sum = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (cand[i]) begin
        value_sum  = value_sum  + SUM_W'(ITEM_VALUE[i]);
        weight_sum = weight_sum + SUM_W'(ITEM_WEIGHT[i]);
        volume_sum = volume_sum + SUM_W'(ITEM_VOLUME[i]);
      end
    end
  end

endmodule

// File: rtl/knap8_sweep.sv
// Exhaustive sweep of all 256 item subsets; feasible ones stream out on a valid/ready port.
// Issue-to-sol_valid latency 2 cycles; a held output stalls issue and both pipeline stages.
module knap8_sweep
  import knap8_pkg::*;
#(
  parameter int MIN_VALUE  = 70,
  parameter int MAX_WEIGHT = 60,
  parameter int MAX_VOLUME = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       sol_valid,
  input  logic       sol_ready,
  output logic [7:0] sol_bits,
  output logic [7:0] sol_value,
  output logic [8:0] sol_count,
  output logic [7:0] best_bits,
  output logic [7:0] best_value,
  output logic       best_found
);

  localparam logic [SUM_W-1:0] MIN_V = SUM_W'(MIN_VALUE);
  localparam logic [SUM_W-1:0] MAX_W = SUM_W'(MAX_WEIGHT);
  localparam logic [SUM_W-1:0] MAX_V = SUM_W'(MAX_VOLUME);

  state_t           state;
  logic [7:0]       cand;
  logic [SUM_W-1:0] ev_value;
  logic [SUM_W-1:0] ev_weight;
  logic [SUM_W-1:0] ev_volume;

  logic             s1_vld;
  logic [7:0]       s1_bits;
  logic [SUM_W-1:0] s1_value;
  logic [SUM_W-1:0] s1_weight;
  logic [SUM_W-1:0] s1_volume;

  logic             stall;
  logic             s1_feasible;

  knap8_eval u_eval (
    .cand       (cand),
    .value_sum  (ev_value),
    .weight_sum (ev_weight),
    .volume_sum (ev_volume)
  );

  assign stall       = sol_valid && !sol_ready;
  assign s1_feasible = s1_vld && (s1_value >= MIN_V) && (s1_weight <= MAX_W) && (s1_volume <= MAX_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= '0;
      s1_vld     <= 1'b0;
      s1_bits    <= '0;
      s1_value   <= '0;
      s1_weight  <= '0;
      s1_volume  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sol_valid  <= 1'b0;
      sol_bits   <= '0;
      sol_value  <= '0;
      sol_count  <= '0;
      best_bits  <= '0;
      best_value <= '0;
      best_found <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state      <= SWEEP;
            busy       <= 1'b1;
            cand       <= '0;
            sol_count  <= '0;
            best_bits  <= '0;
            best_value <= '0;
            best_found <= 1'b0;
          end
        end
        SWEEP: begin
          if (!stall) begin
            s1_vld    <= 1'b1;
            s1_bits   <= cand;
            s1_value  <= ev_value;
            s1_weight <= ev_weight;
            s1_volume <= ev_volume;
            cand      <= cand + 8'd1;
            if (cand == 8'hFF) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Stage 1 empty and nothing held at the output: the last result leaves this edge.
          if (!stall) begin
            s1_vld <= 1'b0;
            if (!s1_vld) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (!stall) begin
        sol_valid <= s1_feasible;
        if (s1_feasible) begin
          sol_bits  <= s1_bits;
          sol_value <= s1_value[7:0];
          sol_count <= sol_count + 9'd1;
          // Strict greater-than keeps the earliest (lowest-index) candidate on ties.
          if (!best_found || (s1_value[7:0] > best_value)) begin
            best_bits  <= s1_bits;
            best_value <= s1_value[7:0];
            best_found <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_knap8_sweep.sv
// Directed bench for knap8_sweep: default, tightened and fully permissive limit sets.
module tb_knap8_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       start_a = 1'b0, ready_a = 1'b1;
  logic       busy_a, done_a, valid_a, found_a;
  logic [7:0] bits_a, value_a, bbits_a, bval_a;
  logic [8:0] count_a;

  logic       start_b = 1'b0, ready_b = 1'b1;
  logic       busy_b, done_b, valid_b, found_b;
  logic [7:0] bits_b, value_b, bbits_b, bval_b;
  logic [8:0] count_b;

  logic       start_c = 1'b0, ready_c = 1'b1;
  logic       busy_c, done_c, valid_c, found_c;
  logic [7:0] bits_c, value_c, bbits_c, bval_c;
  logic [8:0] count_c;

  int n_total = 0;
  int n_pass  = 0;

  knap8_sweep dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .sol_valid(valid_a), .sol_ready(ready_a), .sol_bits(bits_a), .sol_value(value_a),
    .sol_count(count_a), .best_bits(bbits_a), .best_value(bval_a), .best_found(found_a)
  );

  knap8_sweep #(.MIN_VALUE(71)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .sol_valid(valid_b), .sol_ready(ready_b), .sol_bits(bits_b), .sol_value(value_b),
    .sol_count(count_b), .best_bits(bbits_b), .best_value(bval_b), .best_found(found_b)
  );

  knap8_sweep #(.MIN_VALUE(0), .MAX_WEIGHT(255), .MAX_VOLUME(255)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .sol_valid(valid_c), .sol_ready(ready_c), .sol_bits(bits_c), .sol_value(value_c),
    .sol_count(count_c), .best_bits(bbits_c), .best_value(bval_c), .best_found(found_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_value(input logic [7:0] b);
    logic [7:0] vals [8];
    logic [7:0] sum;
    vals = '{8'd4, 8'd8, 8'd0, 8'd20, 8'd10, 8'd12, 8'd18, 8'd14};
    sum = 8'd0;
    for (int i = 0; i < 8; i++) if (b[i]) sum = sum + vals[i];
    return sum;
  endfunction

  // Runs one sweep on dut_a; optionally holds ready low for stall_n valid cycles
  // and pulses start again at loop cycle restart_at.
  task automatic run_sweep_a(input int stall_n, input int restart_at,
                             output int cyc, output int nxfer,
                             output logic [7:0] xbits, output logic [7:0] xval,
                             output bit stable, output bit busy_ok);
    int held;
    cyc = 0; nxfer = 0; xbits = '0; xval = '0; stable = 1'b1; busy_ok = 1'b1; held = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    ready_a = 1'b1;
    while (!done_a && cyc < 1000) begin
      start_a = (cyc == restart_at);
      if (!busy_a) busy_ok = 1'b0;
      if (valid_a) begin
        if (held < stall_n) begin
          ready_a = 1'b0;
          held++;
          if (bits_a !== 8'hDA || value_a !== 8'd70) stable = 1'b0;
        end else begin
          ready_a = 1'b1;
        end
        if (ready_a) begin
          nxfer++;
          xbits = bits_a;
          xval  = value_a;
        end
      end else begin
        ready_a = 1'b1;
      end
      tick();
      cyc++;
    end
    start_a = 1'b0;
    ready_a = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_total++;
    if ({busy_a, done_a, valid_a, bits_a, value_a, count_a, bbits_a, bval_a, found_a} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b valid=%b bits=%h value=%0d count=%0d best=%h/%0d found=%b want all 0",
               busy_a, done_a, valid_a, bits_a, value_a, count_a, bbits_a, bval_a, found_a);
    else n_pass++;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_total++;
    if (busy_a !== 1'b0) $display("FAIL reset_over_start got busy=%b want 0", busy_a);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, nxfer;
    logic [7:0] xbits, xval;
    bit stable, busy_ok;
    run_sweep_a(0, -1, cyc, nxfer, xbits, xval, stable, busy_ok);
    n_total++;
    if (cyc !== 258) $display("FAIL basic_done_latency got %0d want 258", cyc); else n_pass++;
    n_total++;
    if (nxfer !== 1) $display("FAIL basic_transfers got %0d want 1", nxfer); else n_pass++;
    n_total++;
    if (xbits !== 8'hDA || xval !== 8'd70)
      $display("FAIL basic_solution got %h/%0d want da/70", xbits, xval);
    else n_pass++;
    n_total++;
    if (count_a !== 9'd1) $display("FAIL basic_count got %0d want 1", count_a); else n_pass++;
    n_total++;
    if (bbits_a !== 8'hDA || bval_a !== 8'd70 || found_a !== 1'b1)
      $display("FAIL basic_best got %h/%0d found=%b want da/70 found=1", bbits_a, bval_a, found_a);
    else n_pass++;
    n_total++;
    if (busy_ok !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL basic_busy got during=%b at_done=%b want 1/0", busy_ok, busy_a);
    else n_pass++;
    tick();
    n_total++;
    if (done_a !== 1'b0 || count_a !== 9'd1 || bbits_a !== 8'hDA)
      $display("FAIL basic_hold got done=%b count=%0d best=%h want 0/1/da", done_a, count_a, bbits_a);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc, nxfer;
    logic [7:0] xbits, xval;
    bit stable, busy_ok;
    run_sweep_a(20, -1, cyc, nxfer, xbits, xval, stable, busy_ok);
    n_total++;
    if (cyc !== 278) $display("FAIL bp_done_latency got %0d want 278", cyc); else n_pass++;
    n_total++;
    if (stable !== 1'b1) $display("FAIL bp_stable got unstable output while held want da/70"); else n_pass++;
    n_total++;
    if (nxfer !== 1 || xbits !== 8'hDA)
      $display("FAIL bp_transfer got %0d xfers bits=%h want 1 da", nxfer, xbits);
    else n_pass++;
    n_total++;
    if (count_a !== 9'd1) $display("FAIL bp_count got %0d want 1", count_a); else n_pass++;
    tick();
  endtask

  task automatic test_start_while_busy();
    int cyc, nxfer;
    logic [7:0] xbits, xval;
    bit stable, busy_ok;
    run_sweep_a(0, 50, cyc, nxfer, xbits, xval, stable, busy_ok);
    n_total++;
    if (cyc !== 258 || nxfer !== 1 || count_a !== 9'd1 || bbits_a !== 8'hDA)
      $display("FAIL restart_ignored got cyc=%0d xfers=%0d count=%0d best=%h want 258/1/1/da",
               cyc, nxfer, count_a, bbits_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_infeasible();
    int cyc, nvalid;
    cyc = 0; nvalid = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    while (!done_b && cyc < 1000) begin
      if (valid_b) nvalid++;
      tick();
      cyc++;
    end
    n_total++;
    if (cyc !== 258) $display("FAIL min71_done got cyc=%0d want 258", cyc); else n_pass++;
    n_total++;
    if (nvalid !== 0 || count_b !== 9'd0 || found_b !== 1'b0)
      $display("FAIL min71_empty got valids=%0d count=%0d found=%b want 0/0/0", nvalid, count_b, found_b);
    else n_pass++;
  endtask

  task automatic test_all_feasible();
    int cyc, nxfer, errs;
    logic [8:0] exp_idx;
    cyc = 0; nxfer = 0; errs = 0; exp_idx = '0;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    while (!done_c && cyc < 3000) begin
      ready_c = 1'($urandom_range(0, 1));
      if (valid_c && ready_c) begin
        if (bits_c !== exp_idx[7:0] || value_c !== model_value(exp_idx[7:0])) begin
          if (errs == 0)
            $display("FAIL all_order got %h/%0d want %h/%0d", bits_c, value_c,
                     exp_idx[7:0], model_value(exp_idx[7:0]));
          errs++;
        end
        exp_idx = exp_idx + 9'd1;
        nxfer++;
      end
      tick();
      cyc++;
    end
    ready_c = 1'b1;
    n_total++;
    if (errs !== 0 || !done_c) $display("FAIL all_sequence got errs=%0d done=%b want 0/1", errs, done_c);
    else n_pass++;
    n_total++;
    if (nxfer !== 256) $display("FAIL all_transfers got %0d want 256", nxfer); else n_pass++;
    n_total++;
    if (count_c !== 9'd256) $display("FAIL all_count got %0d want 256", count_c); else n_pass++;
    n_total++;
    if (bval_c !== 8'd86 || bbits_c !== 8'hFB || found_c !== 1'b1)
      $display("FAIL all_best got %h/%0d found=%b want fb/86 found=1", bbits_c, bval_c, found_c);
    else n_pass++;
  endtask

  task automatic test_reset_midsweep();
    int cyc, nxfer, bad;
    logic [7:0] xbits, xval;
    bit stable, busy_ok;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_total++;
    if (count_a !== 9'd0 || found_a !== 1'b0 || bval_a !== 8'd0)
      $display("FAIL start_clears got count=%0d found=%b bestval=%0d want 0/0/0", count_a, found_a, bval_a);
    else n_pass++;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    n_total++;
    if ({busy_a, done_a, valid_a, bits_a, value_a, count_a, bbits_a, bval_a, found_a} !== '0)
      $display("FAIL midsweep_reset got busy=%b done=%b valid=%b count=%0d found=%b want all 0",
               busy_a, done_a, valid_a, count_a, found_a);
    else n_pass++;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_a || busy_a) bad++;
      tick();
    end
    n_total++;
    if (bad !== 0) $display("FAIL midsweep_no_done got %0d active cycles want 0", bad); else n_pass++;
    run_sweep_a(0, -1, cyc, nxfer, xbits, xval, stable, busy_ok);
    n_total++;
    if (cyc !== 258 || nxfer !== 1 || xbits !== 8'hDA || count_a !== 9'd1 || bbits_a !== 8'hDA)
      $display("FAIL after_reset_sweep got cyc=%0d xfers=%0d bits=%h count=%0d best=%h want 258/1/da/1/da",
               cyc, nxfer, xbits, count_a, bbits_a);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_infeasible();
    test_all_feasible();
    test_reset_midsweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
